// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constant table, schedule FSM encoding
// and the message-schedule sigma functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, index 0..63 -> K.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  i_idx,
  output logic [31:0] o_k
);

  assign o_k = K_TAB[i_idx];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message scheduler: fills a 16-word window, then streams W_t/K_t to the
// compressor for 64 rounds. Define SHA256_MSG_BSWAP_EN to byte-reverse word_in.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic        compress_start,
  output logic        update_hash,
  output logic        busy,
  output logic        block_done
);

  state_t      r_state;
  logic [31:0] r_win [0:15];
  logic [3:0]  r_fill;
  logic [6:0]  r_rnd;
  logic        r_ready;
  logic        r_busy;
  logic        r_start;
  logic        r_upd;
  logic        r_done;

  logic [31:0] w_word;
  logic [31:0] w_next;
  logic [31:0] w_k;

`ifdef SHA256_MSG_BSWAP_EN
  assign w_word = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
`else
  assign w_word = word_in;
`endif

  assign w_next = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];

  sha256_k_rom u_k_rom (
    .i_idx (r_rnd[5:0]),
    .o_k   (w_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_fill  <= '0;
      r_rnd   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_upd   <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (word_valid) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_word;
            r_fill    <= r_fill + 4'd1;
            if (r_fill == 4'd15) begin
              r_rnd   <= '0;
              r_state <= ST_ROUND;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_ROUND: begin
          // Flags are set one cycle ahead so they line up with the new round index.
          if (r_rnd != 7'd64) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_next;
            r_rnd     <= r_rnd + 7'd1;
            r_start   <= 1'b1;
            r_upd     <= (r_rnd == 7'd63);
          end else begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_upd   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_FILL;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_FILL;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_start <= 1'b0;
          r_upd   <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready     = r_ready;
  assign busy           = r_busy;
  assign compress_start = r_start;
  assign update_hash    = r_upd;
  assign block_done     = r_done;
  assign w_out          = (r_busy && !r_upd) ? r_win[0] : '0;
  assign k_out          = (r_busy && !r_upd) ? w_k : '0;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: reference W/K stream model plus a behavioural
// compressor fed from the DUT outputs, checked against known SHA-256 digests.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [31:0] w_out;
  logic [31:0] k_out;
  logic        compress_start;
  logic        update_hash;
  logic        busy;
  logic        block_done;

  int n_tests = 0;
  int n_fail  = 0;

  sha256_msg_schedule dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .w_out          (w_out),
    .k_out          (k_out),
    .compress_start (compress_start),
    .update_hash    (update_hash),
    .busy           (busy),
    .block_done     (block_done)
  );

  always #5 clk = ~clk;

  logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic [31:0] msg   [16];
  logic [31:0] ref_w [64];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] to_dut(input logic [31:0] x);
`ifdef SHA256_MSG_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // One SHA-256 compression round on packed {a..h}; wk = W_t + K_t.
  function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] wk);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + wk;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return r;
  endfunction

  // Behavioural compressor: latches W+K each cycle, runs a round on compress_start.
  logic [255:0] cm_h, cm_v;
  logic [31:0]  cm_wk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_h  <= IV;
      cm_v  <= IV;
      cm_wk <= '0;
    end else begin
      cm_wk <= w_out + k_out;
      if (busy && !compress_start) cm_v <= cm_h;
      else if (compress_start) begin
        cm_v <= round_fn(cm_v, cm_wk);
        if (update_hash) cm_h <= add8(cm_h, round_fn(cm_v, cm_wk));
      end
    end
  end

  task automatic model_schedule();
    for (int t = 0; t < 16; t++) ref_w[t] = msg[t];
    for (int t = 16; t < 64; t++)
      ref_w[t] = ss1(ref_w[t-2]) + ref_w[t-7] + ss0(ref_w[t-15]) + ref_w[t-16];
  endtask

  task automatic do_reset();
    word_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (word_ready) begin
        word_in = to_dut(w);
        word_valid = 1'b1;
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
      word_valid = 1'b0;
    end
  endtask

  task automatic push_range(input int first, input int last, input int max_gap, output bit ok);
    bit okw;
    ok = 1'b1;
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      push_word(msg[i], okw);
      ok &= okw;
    end
  endtask

  task automatic wait_done(input int start, output int cyc, output bit ok);
    cyc = start;
    while (!block_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    ok = block_done;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({word_ready, busy, block_done, compress_start, update_hash} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 10000", {word_ready, busy, block_done, compress_start, update_hash});
    end
    n_tests++;
    if (w_out !== 32'h0 || k_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got w=%h k=%h want 0", w_out, k_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({word_ready, busy, block_done, compress_start, update_hash, w_out, k_out} !== {5'b10000, 64'h0}) begin
      n_fail++;
      $display("FAIL post_reset got ctrl=%b w=%h k=%h want 10000/0/0",
               {word_ready, busy, block_done, compress_start, update_hash}, w_out, k_out);
    end
  endtask

  task automatic test_schedule_random();
    bit ok;
    logic [4:0]  exp_c;
    logic [31:0] exp_w, exp_k;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++)
        msg[i] = (b == 1) ? 32'hffffffff : ((b == 2 && i[0]) ? 32'ha5a5a5a5 : $urandom);
      model_schedule();
      push_range(0, 15, 3, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL sched_push blk%0d got timeout want accepted", b);
      end
      for (int k = 0; k <= 65; k++) begin
        exp_c = {1'b0, k < 65, k == 65, k >= 1 && k <= 64, k == 64};
        exp_w = (k < 64) ? ref_w[k] : 32'h0;
        exp_k = (k < 64) ? KT[k] : 32'h0;
        n_tests++;
        if ({word_ready, busy, block_done, compress_start, update_hash} !== exp_c) begin
          n_fail++;
          $display("FAIL sched_ctrl blk%0d r=%0d got %b want %b", b, k,
                   {word_ready, busy, block_done, compress_start, update_hash}, exp_c);
        end
        n_tests++;
        if (w_out !== exp_w) begin
          n_fail++;
          $display("FAIL sched_w blk%0d r=%0d got %h want %h", b, k, w_out, exp_w);
        end
        n_tests++;
        if (k_out !== exp_k) begin
          n_fail++;
          $display("FAIL sched_k blk%0d r=%0d got %h want %h", b, k, k_out, exp_k);
        end
        @(negedge clk);
      end
      n_tests++;
      if ({word_ready, busy, block_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL sched_back_to_fill blk%0d got %b want 100", b, {word_ready, busy, block_done});
      end
    end
  endtask

  task automatic test_abc();
    bit ok, dok, cs0, cs1;
    int cyc;
    logic [31:0] w16;
    do_reset();
    msg = '{0: 32'h61626380, 15: 32'h00000018, default: 32'h0};
    push_range(0, 15, 1, ok);
    cs0 = compress_start;
    @(negedge clk);
    cs1 = compress_start;
    repeat (15) @(negedge clk);
    w16 = w_out;
    wait_done(17, cyc, dok);
    n_tests++;
    if (!(ok && dok)) begin
      n_fail++;
      $display("FAIL abc_handshake got push=%0d done=%0d want 1/1", ok, dok);
    end
    n_tests++;
    if (cyc != 66) begin
      n_fail++;
      $display("FAIL abc_latency got %0d want 66", cyc);
    end
    n_tests++;
    if ({cs0, cs1} !== 2'b01) begin
      n_fail++;
      $display("FAIL abc_start_edge got %b want 01", {cs0, cs1});
    end
    n_tests++;
    if (w16 !== 32'h61626380) begin
      n_fail++;
      $display("FAIL abc_w16 got %h want 61626380", w16);
    end
    n_tests++;
    if (cm_h[255:224] !== 32'hba7816bf) begin
      n_fail++;
      $display("FAIL abc_h0 got %h want ba7816bf", cm_h[255:224]);
    end
    @(negedge clk);
  endtask

  task automatic test_empty();
    bit ok, dok;
    int cyc;
    do_reset();
    msg = '{0: 32'h80000000, default: 32'h0};
    push_range(0, 15, 0, ok);
    wait_done(1, cyc, dok);
    n_tests++;
    if (!(ok && dok) || cm_h[255:224] !== 32'he3b0c442) begin
      n_fail++;
      $display("FAIL empty_h0 got %h want e3b0c442", cm_h[255:224]);
    end
    n_tests++;
    if (cm_h[31:0] !== 32'h7852b855) begin
      n_fail++;
      $display("FAIL empty_h7 got %h want 7852b855", cm_h[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_two_block();
    bit ok1, ok2, d1, d2;
    int cyc;
    do_reset();
    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    push_range(0, 15, 2, ok1);
    wait_done(1, cyc, d1);
    @(negedge clk);
    msg = '{15: 32'h000001c0, default: 32'h0};
    push_range(0, 15, 2, ok2);
    wait_done(1, cyc, d2);
    n_tests++;
    if (!(ok1 && ok2 && d1 && d2) || cm_h[255:224] !== 32'h248d6a61) begin
      n_fail++;
      $display("FAIL two_block_h0 got %h want 248d6a61", cm_h[255:224]);
    end
    @(negedge clk);
  endtask

  task automatic test_valid_held();
    bit ok, okw;
    int cnt;
    logic [31:0] h0;
    do_reset();
    msg = '{0: 32'h80000000, default: 32'h0};
    push_range(0, 15, 0, ok);
    cnt = 0;
    h0 = '0;
    word_valid = 1'b1;
    while (!word_ready && cnt < 300) begin
      word_in = $urandom;
      if (block_done) h0 = cm_h[255:224];
      @(negedge clk);
      cnt++;
    end
    word_valid = 1'b0;
    n_tests++;
    if (!ok || cnt != 66) begin
      n_fail++;
      $display("FAIL held_ready_low got %0d cycles want 66", cnt);
    end
    n_tests++;
    if (h0 !== 32'he3b0c442) begin
      n_fail++;
      $display("FAIL held_h0 got %h want e3b0c442", h0);
    end
    for (int i = 0; i < 15; i++) push_word(32'h0, okw);
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL held_no_transfer got busy=%b ready=%b want 0/1", busy, word_ready);
    end
  endtask

  task automatic test_partial_hold();
    bit ok1, ok2, dok;
    int bad, cyc;
    do_reset();
    msg = '{0: 32'h80000000, default: 32'h0};
    push_range(0, 9, 1, ok1);
    bad = 0;
    repeat (200) begin
      if (busy !== 1'b0 || word_ready !== 1'b1 || block_done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL partial_hold got %0d bad cycles want 0", bad);
    end
    push_range(10, 15, 1, ok2);
    wait_done(1, cyc, dok);
    n_tests++;
    if (!(ok1 && ok2 && dok) || cm_h[255:224] !== 32'he3b0c442) begin
      n_fail++;
      $display("FAIL partial_h0 got %h want e3b0c442", cm_h[255:224]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_round();
    bit ok, dok;
    int cyc;
    do_reset();
    msg = '{0: 32'h61626380, 15: 32'h00000018, default: 32'h0};
    push_range(0, 15, 0, ok);
    repeat (30) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || compress_start !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre got busy=%b cs=%b want 1/1", busy, compress_start);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({word_ready, busy, block_done, compress_start, update_hash, w_out, k_out} !== {5'b10000, 64'h0}) begin
      n_fail++;
      $display("FAIL midrst_outputs got ctrl=%b w=%h k=%h want 10000/0/0",
               {word_ready, busy, block_done, compress_start, update_hash}, w_out, k_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_range(0, 15, 1, ok);
    wait_done(1, cyc, dok);
    n_tests++;
    if (!(ok && dok) || cm_h[255:224] !== 32'hba7816bf) begin
      n_fail++;
      $display("FAIL midrst_abc_h0 got %h want ba7816bf", cm_h[255:224]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_schedule_random();
    test_abc();
    test_empty();
    test_two_block();
    test_valid_held();
    test_partial_hold();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_msg_schedule.md
SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 SHALL have no parameters; all sizes are fixed by SHA-256.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 word_in  in  32  message word, one per handshake, first word of block first.
REQ-005 word_valid  in  1  word_in valid.
REQ-006 word_ready  out  1  block can accept a word; transfer occurs when word_valid&&word_ready.
REQ-007 w_out  out  32  schedule word W_t, feeds compressor w_in.
REQ-008 k_out  out  32  round constant K_t, feeds compressor k_in.
REQ-009 compress_start  out  1  compressor round enable.
REQ-010 update_hash  out  1  compressor hash accumulate strobe.
REQ-011 busy  out  1  high while in ROUND state.
REQ-012 block_done  out  1  one-cycle pulse: compressor H8 holds updated hash.

Function
REQ-013 FSM states: FILL, ROUND, DONE; reset state FILL.
REQ-014 FILL: word_ready=1; each transfer shifts the 16-entry window (w[i]<=w[i+1], w[15]<=word); 4-bit fill counter increments.
REQ-015 16th transfer: fill counter wraps to 0, round counter r<=0, FSM->ROUND next cycle.
REQ-016 ROUND: word_ready=0, busy=1; r counts 0..64 (7-bit); word_valid ignored.
REQ-017 r=0: compress_start=0, w_out=w[0] (W0), k_out=K0.
REQ-018 r=1..63: compress_start=1, w_out=w[0] (W_r), k_out=K_r.
REQ-019 r=64: compress_start=1, update_hash=1, w_out=0, k_out=0; FSM->DONE.
REQ-020 Every ROUND cycle with r<=63: window shifts, w[15]<=sigma1(w[14])+w[9]+sigma0(w[1])+w[0], modulo 2^32.
REQ-021 sigma0(x)=ror7^ror18^shr3; sigma1(x)=ror17^ror19^shr10.
REQ-022 DONE: block_done=1 for exactly one cycle, FSM->FILL; a word transfer is not accepted in DONE.
REQ-023 Outside ROUND: compress_start=0, update_hash=0, w_out=0, k_out=0.
REQ-024 The compressor's chaining state is not reinitialised; consecutive blocks chain a multi-block message; a new message requires rst_n.
REQ-025 Partial fill (fewer than 16 words) SHALL hold indefinitely; no timeout.
REQ-026 Padding is the caller's responsibility; the block processes raw 512-bit blocks.

Reset
REQ-027 rst_n low: FSM=FILL, counters=0, window=0, word_ready=1, busy=0, block_done=0, compress_start=0, update_hash=0, w_out=0, k_out=0.
REQ-028 Reset mid-ROUND discards the block; the next block starts fill from word 0.

Configuration
REQ-029 Macro SHA256_MSG_BSWAP_EN defined: word_in is byte-reversed on entry ({[7:0],[15:8],[23:16],[31:24]}), matching little-endian AXI.
REQ-030 Macro undefined: word_in is used unchanged as a big-endian SHA word.

Structure
REQ-031 Package sha256_pkg SHALL hold the 64-entry K constant table, FSM state encoding, and sigma0/sigma1 functions.
REQ-032 Sub-module sha256_k_rom (combinational index 0..63 -> K) SHALL provide k_out.

Verification
REQ-033 "abc" block, bswap enabled: words 0x80636261, 13x0, 0x00000000, 0x18000000 -> block_done 66 cycles after the last word; compressor H8[0]=0xba7816bf, so its hash0 port reads 0xbf1678ba.
REQ-034 Empty message, bswap disabled: 0x80000000, 15x0 -> H8[0]=0xe3b0c442, H8[7]=0x7852b855.
REQ-035 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> H8[0]=0x248d6a61 after the second block_done.
REQ-036 word_valid held high during ROUND -> no transfers; word_ready=0 for 66 cycles (ROUND plus DONE).
REQ-037 rst_n pulse at r=30 -> all outputs reset values; a fresh "abc" block then gives H8[0]=0xba7816bf.
REQ-038 Scoreboard: W16 for "abc" = 0x61626380; compress_start rises exactly one cycle after r=0.
